mem_dump_streamer: RTL and testbench
====================================

# mem_dump_streamer

Read-out engine for the four byte-lane instruction/data memory banks (`memInside_0..3`, bank *n* holds byte *n* of each 32-bit word). It runs as a post-run dump path: after a benchmark image (e.g. drystone) has executed, it walks a word range, reads the four banks, and emits the bytes little-endian over a valid/ready byte stream toward the host/testbench. It is the read-out counterpart of the per-bank image preload. It sits beside `mem` and shares the banks' read port while the core is held in reset.

## Interface
Parameters:
- `ADDR_W`, 14, word-address width of each bank (depth 2^ADDR_W bytes per bank)

Ports:
- `clock` input 1: single clock; all state on rising edge
- `reset` input 1: synchronous, active-high
- `io_start` input 1: start pulse; sampled only in IDLE
- `io_baseWord` input ADDR_W: first word index, latched on accepted start
- `io_lenWords` input ADDR_W+1: word count, latched on accepted start
- `io_busy` output 1: high in every state except IDLE
- `io_done` output 1: one-cycle pulse at end of dump
- `io_bankRdEn` output 1: bank read enable
- `io_bankRdAddr` output ADDR_W: word address to all four banks
- `io_bankRdData_0`..`io_bankRdData_3` input 8 each: bank read data, valid the cycle after `io_bankRdEn`
- `io_out_valid` output 1: byte available
- `io_out_ready` input 1: sink accepts byte
- `io_out_bits` output 8: byte data

## Operation
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: on `io_start`=1, latch base into word pointer `ptr` and length into `remain`.
  - If length = 0: go to DONE.
  - Otherwise go to READ.
- READ: drive `io_bankRdEn`=1 and `io_bankRdAddr`=`ptr` for exactly one cycle, then go to WAIT.
- WAIT: capture `io_bankRdData_0..3` into a 4-byte buffer at end of cycle. Set `idx`=0, `ptr`=`ptr`+1 (mod 2^ADDR_W, wraps silently), `remain`=`remain`-1. Go to SEND.
- SEND: `io_out_valid`=1, `io_out_bits`=buffer[`idx`] (byte0 = bank0 first).
  - Handshake = valid & ready; each handshake increments `idx`.
  - On the handshake with `idx`=3: go to READ if `remain`≠0, else DONE.
  - With ready low, valid and bits hold stable; nothing advances.
- DONE: `io_done`=1 for one cycle, then IDLE.
- `io_start` outside IDLE is ignored; no queuing.
- `io_bankRdEn` is 0 in every state except READ. `io_bankRdAddr` always shows `ptr`.
- Reset from any state: return to IDLE and drop valid the next cycle. The partial dump is discarded and no done pulse is produced.

## Timing
- Reset values: `io_busy`=0, `io_done`=0, `io_bankRdEn`=0, `io_bankRdAddr`=0, `io_out_valid`=0, `io_out_bits`=0. Internal `ptr`=0, `remain`=0, `idx`=0, buffer=0.
- Start accepted at edge of cycle T:
  - READ in T+1.
  - WAIT in T+2.
  - First `io_out_valid` in T+3.
- Minimum 6 cycles per word with ready tied high: READ, WAIT, 4×SEND.
- Back-to-back words: READ immediately follows the last SEND handshake.
- `io_done` is asserted the cycle after the final byte handshake (or T+1 for length 0). `io_busy` is high during DONE and falls in the following cycle.
- `io_lenWords` = 2^ADDR_W dumps the whole bank, ending with `ptr` back at base.
- Combinational paths: none from `io_out_ready` to any output except through state registers. `io_out_valid` and `io_out_bits` are registered-state functions.

## Test plan
- Banks at word 5 = {0x78,0x56,0x34,0x12}, start base=5 len=1, ready=1 → `io_bankRdEn`=1 with addr 5 at T+1. Bytes 0x78,0x56,0x34,0x12 on T+3..T+6. `io_done` at T+7, `io_busy`=0 at T+8.
- len=0, start → no `io_bankRdEn`, no valid, `io_done` at T+1.
- base=2^ADDR_W−1, len=2 → reads at addr 2^ADDR_W−1 then 0. 8 bytes out in order.
- len=3, ready toggled 1/0 every cycle → 12 bytes, each held stable while ready=0, no byte lost or duplicated, done once.
- `io_start` pulsed again during SEND with different base → ignored; original dump completes unchanged.
- `reset` asserted mid-SEND (byte 2 of word 1) → next cycle IDLE, valid=0, busy=0, no done. A subsequent start dumps correctly from the new base.

Source files
------------

// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer: walks a word range of the four byte-lane banks and
// streams each word out little-endian over a valid/ready byte interface.
module mem_dump_streamer #(
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_start,
   input  logic [ADDR_W-1:0] io_baseWord,
   input  logic [ADDR_W:0]   io_lenWords,
   output logic              io_busy,
   output logic              io_done,
   output logic              io_bankRdEn,
   output logic [ADDR_W-1:0] io_bankRdAddr,
   input  logic [7:0]        io_bankRdData_0,
   input  logic [7:0]        io_bankRdData_1,
   input  logic [7:0]        io_bankRdData_2,
   input  logic [7:0]        io_bankRdData_3,
   output logic              io_out_valid,
   input  logic              io_out_ready,
   output logic [7:0]        io_out_bits
);

   localparam int unsigned LEN_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_WAIT = 3'd2,
      S_SEND = 3'd3,
      S_DONE = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [LEN_W-1:0]  remain_q, remain_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0][7:0]   byte_buf_q, byte_buf_d;

   logic              handshake;
   assign handshake = (state_q == S_SEND) && io_out_ready;

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (io_start) state_d = (io_lenWords == '0) ? S_DONE : S_READ;
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: state_d = S_SEND;
         S_SEND: begin
            if (handshake && (idx_q == 2'd3)) state_d = (remain_q != '0) ? S_READ : S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from registered state only; ready never reaches them combinationally
   always_comb begin
      io_busy       = (state_q != S_IDLE);
      io_done       = (state_q == S_DONE);
      io_bankRdEn   = (state_q == S_READ);
      io_bankRdAddr = ptr_q;
      io_out_valid  = (state_q == S_SEND);
      io_out_bits   = (state_q == S_SEND) ? byte_buf_q[idx_q] : 8'h00;
   end

   // Datapath next values: latch range on start, capture word in WAIT, step byte index on handshake
   always_comb begin
      ptr_d      = ptr_q;
      remain_d   = remain_q;
      idx_d      = idx_q;
      byte_buf_d = byte_buf_q;
      case (state_q)
         S_IDLE: begin
            if (io_start) begin
               ptr_d    = io_baseWord;
               remain_d = io_lenWords;
            end
         end
         S_WAIT: begin
            byte_buf_d = {io_bankRdData_3, io_bankRdData_2, io_bankRdData_1, io_bankRdData_0};
            idx_d      = 2'd0;
            ptr_d      = ptr_q + ADDR_W'(1);
            remain_d   = remain_q - LEN_W'(1);
         end
         S_SEND: begin
            if (handshake) idx_d = idx_q + 2'd1;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q      <= '0;
         remain_q   <= '0;
         idx_q      <= '0;
         byte_buf_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         remain_q   <= remain_d;
         idx_q      <= idx_d;
         byte_buf_q <= byte_buf_d;
      end
   end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Scoreboard bench for mem_dump_streamer with a behavioural bank model.
module tb_mem_dump_streamer;

   localparam int unsigned AW     = 6;
   localparam int unsigned DEPTH  = 1 << AW;
   localparam int          BUDGET = 5000;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          io_start = 1'b0;
   logic [AW-1:0] io_baseWord = '0;
   logic [AW:0]   io_lenWords = '0;
   logic          io_busy, io_done, io_bankRdEn, io_out_valid;
   logic [AW-1:0] io_bankRdAddr;
   logic [7:0]    rd0 = '0, rd1 = '0, rd2 = '0, rd3 = '0;
   logic          io_out_ready = 1'b1;
   logic [7:0]    io_out_bits;

   mem_dump_streamer #(.ADDR_W(AW)) dut (
      .clock(clock), .reset(reset), .io_start(io_start),
      .io_baseWord(io_baseWord), .io_lenWords(io_lenWords),
      .io_busy(io_busy), .io_done(io_done),
      .io_bankRdEn(io_bankRdEn), .io_bankRdAddr(io_bankRdAddr),
      .io_bankRdData_0(rd0), .io_bankRdData_1(rd1),
      .io_bankRdData_2(rd2), .io_bankRdData_3(rd3),
      .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
      .io_out_bits(io_out_bits)
   );

   always #5 clock = ~clock;

   // Bank model: one-cycle read latency
   logic [7:0] bank [4][DEPTH];
   always @(posedge clock) begin
      if (io_bankRdEn) begin
         rd0 <= bank[0][io_bankRdAddr];
         rd1 <= bank[1][io_bankRdAddr];
         rd2 <= bank[2][io_bankRdAddr];
         rd3 <= bank[3][io_bankRdAddr];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Scoreboard state
   logic [7:0]    exp_q[$];
   logic [AW-1:0] addr_q[$];
   int            done_pend = 0;
   int            hs_seen = 0;

   // Reference: a dump of len words from base is the bytes of words base..base+len-1 (mod DEPTH), bank0 first
   task automatic push_dump(input logic [AW-1:0] b, input logic [AW:0] l);
      for (int w = 0; w < int'(l); w++) begin
         logic [AW-1:0] a;
         a = AW'((int'(b) + w) % DEPTH);
         addr_q.push_back(a);
         for (int k = 0; k < 4; k++) exp_q.push_back(bank[k][a]);
      end
      done_pend++;
   endtask

   // Ready driver
   int ready_mode = 0;
   always @(posedge clock) begin
      #1;
      case (ready_mode)
         0:       io_out_ready = 1'b1;
         1:       io_out_ready = ~io_out_ready;
         2:       io_out_ready = ($urandom_range(0, 99) < 70);
         default: io_out_ready = 1'b0;
      endcase
   end

   // Monitor: compares reads, bytes and done pulses against the scoreboard
   logic       prev_hold = 1'b0;
   logic [7:0] prev_bits = '0;
   always @(negedge clock) begin
      if (reset) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", 32'(io_out_valid), 32'd1);
            check("hold_bits", 32'(io_out_bits), 32'(prev_bits));
         end
         if (io_bankRdEn) begin
            check("rd_expected", 32'(addr_q.size() > 0), 32'd1);
            if (addr_q.size() > 0) check("rd_addr", 32'(io_bankRdAddr), 32'(addr_q.pop_front()));
         end
         if (io_out_valid && io_out_ready) begin
            hs_seen++;
            check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("byte", 32'(io_out_bits), 32'(exp_q.pop_front()));
         end
         if (io_done) begin
            check("done_expected", 32'(done_pend > 0), 32'd1);
            if (done_pend > 0) done_pend--;
         end
         prev_hold = io_out_valid && !io_out_ready;
         prev_bits = io_out_bits;
      end
   end

   // Pulse start for one cycle; returns just after the edge that accepted it
   task automatic start_dump(input logic [AW-1:0] b, input logic [AW:0] l, input bit exp_en);
      @(posedge clock); #1;
      if (exp_en) push_dump(b, l);
      io_start    = 1'b1;
      io_baseWord = b;
      io_lenWords = l;
      @(posedge clock); #1;
      io_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!io_done && n < BUDGET);
      check({name, "_done"}, 32'(io_done), 32'd1);
      @(negedge clock);
      check({name, "_busy_low"}, 32'(io_busy), 32'd0);
   endtask

   initial begin
      logic [AW-1:0] b;
      int            n;
      int            h0;

      for (int k = 0; k < 4; k++)
         for (int a = 0; a < int'(DEPTH); a++) bank[k][a] = 8'($urandom);
      bank[0][5] = 8'h78; bank[1][5] = 8'h56; bank[2][5] = 8'h34; bank[3][5] = 8'h12;

      // Reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_busy", 32'(io_busy), 32'd0);
      check("rst_done", 32'(io_done), 32'd0);
      check("rst_rden", 32'(io_bankRdEn), 32'd0);
      check("rst_addr", 32'(io_bankRdAddr), 32'd0);
      check("rst_valid", 32'(io_out_valid), 32'd0);
      check("rst_bits", 32'(io_out_bits), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Single word at base 5: cycle-exact timing
      ready_mode = 0;
      start_dump(AW'(5), (AW+1)'(1), 1'b1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         check($sformatf("t1_rden_T%0d", k), 32'(io_bankRdEn), 32'(k == 1));
         check($sformatf("t1_valid_T%0d", k), 32'(io_out_valid), 32'(k >= 3 && k <= 6));
         check($sformatf("t1_done_T%0d", k), 32'(io_done), 32'(k == 7));
         check($sformatf("t1_busy_T%0d", k), 32'(io_busy), 32'(k <= 7));
      end

      // Zero length: done at T+1, nothing read or sent
      start_dump(AW'(7), '0, 1'b1);
      @(negedge clock);
      check("len0_done", 32'(io_done), 32'd1);
      check("len0_rden", 32'(io_bankRdEn), 32'd0);
      check("len0_valid", 32'(io_out_valid), 32'd0);
      @(negedge clock);
      check("len0_busy", 32'(io_busy), 32'd0);

      // Address wrap at top of bank
      start_dump(AW'(DEPTH - 1), (AW+1)'(2), 1'b1);
      wait_done("wrap");

      // Ready toggling every cycle
      ready_mode = 1;
      start_dump(AW'($urandom), (AW+1)'(3), 1'b1);
      wait_done("toggle");

      // Start during SEND is ignored
      ready_mode = 0;
      start_dump(AW'(10), (AW+1)'(2), 1'b1);
      n = 0;
      do begin @(negedge clock); n++; end while (!io_out_valid && n < BUDGET);
      check("ign_valid_seen", 32'(io_out_valid), 32'd1);
      @(posedge clock); #1;
      io_start = 1'b1; io_baseWord = AW'(30); io_lenWords = (AW+1)'(5);
      @(posedge clock); #1;
      io_start = 1'b0;
      wait_done("ignore");
      repeat (10) @(posedge clock);

      // Reset mid-SEND, at byte 2 of word 1
      ready_mode = 0;
      h0 = hs_seen;
      start_dump(AW'(20), (AW+1)'(3), 1'b1);
      n = 0;
      while (hs_seen < h0 + 6 && n < BUDGET) begin @(posedge clock); n++; end
      check("rst_mid_reached", 32'(hs_seen >= h0 + 6), 32'd1);
      #1;
      reset = 1'b1; ready_mode = 3; io_out_ready = 1'b0;
      @(negedge clock);
      check("rst_mid_pre_valid", 32'(io_out_valid), 32'd1);
      @(negedge clock);
      check("rst_mid_valid", 32'(io_out_valid), 32'd0);
      check("rst_mid_busy", 32'(io_busy), 32'd0);
      check("rst_mid_done", 32'(io_done), 32'd0);
      @(posedge clock); #1;
      exp_q.delete(); addr_q.delete(); done_pend = 0;
      reset = 1'b0; ready_mode = 0;
      repeat (8) @(posedge clock);
      start_dump(AW'(40), (AW+1)'(2), 1'b1);
      wait_done("after_rst");

      // Randomized dumps with random backpressure
      ready_mode = 2;
      for (int t = 0; t < 8; t++) begin
         start_dump(AW'($urandom), (AW+1)'($urandom_range(1, 6)), 1'b1);
         wait_done($sformatf("rand%0d", t));
      end

      // Whole bank; pointer returns to base
      ready_mode = 0;
      b = AW'($urandom);
      start_dump(b, (AW+1)'(DEPTH), 1'b1);
      wait_done("full");
      check("full_ptr_base", 32'(io_bankRdAddr), 32'(b));

      repeat (4) @(posedge clock);
      check("sb_bytes_left", 32'(exp_q.size()), 32'd0);
      check("sb_reads_left", 32'(addr_q.size()), 32'd0);
      check("sb_done_left", 32'(done_pend), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
